fft_pe: RTL and testbench

Radix-2 decimation-in-frequency butterfly processing element for a 16-point complex FFT datapath. Each accepted sample pair (a, b) produces fft_a = a + b and fft_b = (a − b)·W16^power, where W16^k = e^(−j2πk/16). The block is fully pipelined with throughput of one pair per clock. It is instantiated per stage by the FFT controller, which sequences power.

---
 rtl/fft_pkg.sv | 23 ++
 rtl/fft_cmul.sv | 39 +++
 rtl/fft_pe.sv | 88 ++++++++
 tb/tb_fft_pe.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared definitions for the 16-point FFT datapath: data format, complex sample
// type and the W16^k twiddle table (Q8.8, k = 0..7).
package fft_pkg;

    localparam int DW   = 16;
    localparam int FRAC = 8;

    typedef struct packed {
        logic signed [DW-1:0] re;
        logic signed [DW-1:0] im;
    } cplx_t;

    // W16^k = cos(2*pi*k/16) - j*sin(2*pi*k/16), rounded to Q8.8
    localparam logic signed [DW-1:0] W16_RE [8] = '{
        16'sd256, 16'sd237, 16'sd181, 16'sd98,
        16'sd0, -16'sd98, -16'sd181, -16'sd237
    };
    localparam logic signed [DW-1:0] W16_IM [8] = '{
        16'sd0, -16'sd98, -16'sd181, -16'sd237,
        -16'sd256, -16'sd237, -16'sd181, -16'sd98
    };

endpackage

// File: rtl/fft_cmul.sv
// Combinational complex multiply (x + jy)(c + jd), full-precision products,
// arithmetic shift right by FRAC and wrap to DW bits.
module fft_cmul #(
    parameter int DW   = 16,
    parameter int FRAC = 8
) (
    input  logic signed [DW-1:0] i_x_re,
    input  logic signed [DW-1:0] i_x_im,
    input  logic signed [DW-1:0] i_c,
    input  logic signed [DW-1:0] i_d,
    output logic signed [DW-1:0] o_re,
    output logic signed [DW-1:0] o_im
);

    logic signed [2*DW-1:0] w_xc;
    logic signed [2*DW-1:0] w_yd;
    logic signed [2*DW-1:0] w_xd;
    logic signed [2*DW-1:0] w_yc;
    logic signed [2*DW:0]   w_re_full;
    logic signed [2*DW:0]   w_im_full;
    logic                   w_unused;

    assign w_xc = i_x_re * i_c;
    assign w_yd = i_x_im * i_d;
    assign w_xd = i_x_re * i_d;
    assign w_yc = i_x_im * i_c;

    // One guard bit keeps the sum of two full-scale products exact
    assign w_re_full = {w_xc[2*DW-1], w_xc} - {w_yd[2*DW-1], w_yd};
    assign w_im_full = {w_xd[2*DW-1], w_xd} + {w_yc[2*DW-1], w_yc};

    // Taking bits [FRAC+DW-1:FRAC] is an arithmetic shift (floor) then wrap
    assign o_re = w_re_full[FRAC+DW-1:FRAC];
    assign o_im = w_im_full[FRAC+DW-1:FRAC];

    assign w_unused = ^{w_re_full[2*DW:FRAC+DW], w_re_full[FRAC-1:0],
                        w_im_full[2*DW:FRAC+DW], w_im_full[FRAC-1:0]};

endmodule

// File: rtl/fft_pe.sv
// Radix-2 DIF butterfly: fft_a = a + b, fft_b = (a - b) * W16^power.
// Two register stages, one pair per clock, no back-pressure.
module fft_pe
    import fft_pkg::*;
#(
    parameter int DW   = fft_pkg::DW,
    parameter int FRAC = fft_pkg::FRAC
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [2*DW-1:0] a,
    input  logic [2*DW-1:0] b,
    input  logic            ab_valid,
    input  logic [2:0]      power,
    output logic [2*DW-1:0] fft_a,
    output logic [2*DW-1:0] fft_b,
    output logic            fft_pe_valid
);

    cplx_t       w_a;
    cplx_t       w_b;
    cplx_t       w_sum;
    cplx_t       w_diff;
    cplx_t       w_prod;
    logic signed [DW-1:0] w_c;
    logic signed [DW-1:0] w_d;

    logic        r_v1;
    cplx_t       r_sum;
    cplx_t       r_diff;
    logic [2:0]  r_pow;

    assign w_a = a;
    assign w_b = b;

    assign w_sum.re  = w_a.re + w_b.re;
    assign w_sum.im  = w_a.im + w_b.im;
    assign w_diff.re = w_a.re - w_b.re;
    assign w_diff.im = w_a.im - w_b.im;

    // Stage 1: data registers load only on accepted pairs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v1   <= 1'b0;
            r_sum  <= '0;
            r_diff <= '0;
            r_pow  <= '0;
        end else begin
            r_v1 <= ab_valid;
            if (ab_valid) begin
                r_sum  <= w_sum;
                r_diff <= w_diff;
                r_pow  <= power;
            end
        end
    end

    assign w_c = W16_RE[r_pow];
    assign w_d = W16_IM[r_pow];

    fft_cmul #(
        .DW   (DW),
        .FRAC (FRAC)
    ) u_cmul (
        .i_x_re (r_diff.re),
        .i_x_im (r_diff.im),
        .i_c    (w_c),
        .i_d    (w_d),
        .o_re   (w_prod.re),
        .o_im   (w_prod.im)
    );

    // Stage 2: outputs hold through bubbles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fft_pe_valid <= 1'b0;
            fft_a        <= '0;
            fft_b        <= '0;
        end else begin
            fft_pe_valid <= r_v1;
            if (r_v1) begin
                fft_a <= r_sum;
                fft_b <= w_prod;
            end
        end
    end

endmodule

// File: tb/tb_fft_pe.sv
// Directed bench for fft_pe: known butterflies, a twiddle sweep checked against
// a real-valued reference, bubbles, and asynchronous reset with pairs in flight.
module tb_fft_pe;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a;
    logic [31:0] b;
    logic        ab_valid;
    logic [2:0]  power;
    logic [31:0] fft_a;
    logic [31:0] fft_b;
    logic        fft_pe_valid;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] exp_q[$];

    int tw_re[8] = '{256, 237, 181, 98, 0, -98, -181, -237};
    int tw_im[8] = '{0, -98, -181, -237, -256, -237, -181, -98};

    always #5 clk = ~clk;

    fft_pe dut (
        .clk          (clk),
        .rst          (rst),
        .a            (a),
        .b            (b),
        .ab_valid     (ab_valid),
        .power        (power),
        .fft_a        (fft_a),
        .fft_b        (fft_b),
        .fft_pe_valid (fft_pe_valid)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_near(input string tag, input logic [15:0] obs, input real ref_v);
        real d;
        d = $itor($signed(obs)) - ref_v;
        n_tests++;
        assert (d <= 1.0 && d >= -1.0) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %f (+/-1)", tag, $signed(obs), ref_v);
        end
    endtask

    task automatic drive(input logic [31:0] ta, input logic [31:0] tb, input logic [2:0] tp);
        a        = ta;
        b        = tb;
        power    = tp;
        ab_valid = 1'b1;
    endtask

    task automatic idle_x();
        a        = 'x;
        b        = 'x;
        power    = 'x;
        ab_valid = 1'b0;
    endtask

    function automatic logic [31:0] exp_sum(input logic [31:0] ta, input logic [31:0] tb);
        logic [15:0] sr;
        logic [15:0] si;
        sr = ta[31:16] + tb[31:16];
        si = ta[15:0] + tb[15:0];
        return {sr, si};
    endfunction

    function automatic real ref_b_re(input logic [31:0] ta, input logic [31:0] tb, input int k);
        logic signed [15:0] x;
        logic signed [15:0] y;
        x = ta[31:16] - tb[31:16];
        y = ta[15:0] - tb[15:0];
        return ($itor(x) * tw_re[k] - $itor(y) * tw_im[k]) / 256.0;
    endfunction

    function automatic real ref_b_im(input logic [31:0] ta, input logic [31:0] tb, input int k);
        logic signed [15:0] x;
        logic signed [15:0] y;
        x = ta[31:16] - tb[31:16];
        y = ta[15:0] - tb[15:0];
        return ($itor(x) * tw_im[k] + $itor(y) * tw_re[k]) / 256.0;
    endfunction

    function automatic logic [31:0] rand_q88();
        logic [15:0] re;
        logic [15:0] im;
        re = 16'($signed($urandom_range(0, 1023)) - 512);
        im = 16'($signed($urandom_range(0, 1023)) - 512);
        return {re, im};
    endfunction

    logic [31:0] sa[8];
    logic [31:0] sb[8];
    int          pat[8] = '{1, 0, 1, 1, 0, 0, 1, 0};
    logic [31:0] ba;
    logic [31:0] bb;
    logic [31:0] last_a;
    logic [31:0] last_b;

    initial begin
        // Reset
        rst      = 1'b1;
        a        = '0;
        b        = '0;
        power    = '0;
        ab_valid = 1'b0;
        repeat (3) @(negedge clk);
        check1("reset_valid", fft_pe_valid, 1'b0);
        check32("reset_fft_a", fft_a, 32'h0);
        check32("reset_fft_b", fft_b, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Directed butterflies, back-to-back
        drive(32'h0100_0000, 32'h0080_0000, 3'd0);
        @(negedge clk);
        check1("k0_not_yet_valid", fft_pe_valid, 1'b0);
        drive(32'h0100_0000, 32'h0080_0000, 3'd4);
        @(negedge clk);
        check1("k0_valid", fft_pe_valid, 1'b1);
        check32("k0_fft_a", fft_a, 32'h0180_0000);
        check32("k0_fft_b", fft_b, 32'h0080_0000);
        drive(32'h0100_0000, 32'h0000_0000, 3'd2);
        @(negedge clk);
        check1("k4_valid", fft_pe_valid, 1'b1);
        check32("k4_fft_a", fft_a, 32'h0180_0000);
        check32("k4_fft_b", fft_b, 32'h0000_FF80);
        idle_x();
        @(negedge clk);
        check1("k2_valid", fft_pe_valid, 1'b1);
        check32("k2_fft_a", fft_a, 32'h0100_0000);
        check32("k2_fft_b", fft_b, 32'h00B5_FF4B);
        @(negedge clk);
        check1("idle_valid", fft_pe_valid, 1'b0);
        check32("idle_hold_b", fft_b, 32'h00B5_FF4B);

        // Twiddle sweep k = 0..7 with random data
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                check1("sweep_valid", fft_pe_valid, 1'b1);
                check32("sweep_fft_a", fft_a, exp_q.pop_front());
                check_near("sweep_b_re", fft_b[31:16], ref_b_re(sa[i-2], sb[i-2], i - 2));
                check_near("sweep_b_im", fft_b[15:0], ref_b_im(sa[i-2], sb[i-2], i - 2));
            end
            if (i < 8) begin
                sa[i] = rand_q88();
                sb[i] = rand_q88();
                drive(sa[i], sb[i], 3'(i));
                exp_q.push_back(exp_sum(sa[i], sb[i]));
            end else begin
                idle_x();
            end
        end
        @(negedge clk);
        check1("sweep_drain_valid", fft_pe_valid, 1'b0);

        // Bubbles: valid pattern delayed by two cycles, outputs hold in gaps
        last_a = fft_a;
        last_b = fft_b;
        for (int i = 0; i < 10; i++) begin
            if (i >= 2) begin
                if (pat[i-2] == 1) begin
                    last_a = exp_q.pop_front();
                    last_b = exp_q.pop_front();
                end
                check1("bubble_valid", fft_pe_valid, pat[i-2] == 1);
                check32("bubble_fft_a", fft_a, last_a);
                check32("bubble_fft_b", fft_b, last_b);
            end
            if (i < 8 && pat[i] == 1) begin
                ba = 32'h0100_0200 + 32'(i) * 32'h0003_0005;
                bb = 32'h0040_0010;
                drive(ba, bb, 3'd0);
                exp_q.push_back(exp_sum(ba, bb));
                exp_q.push_back({ba[31:16] - bb[31:16], ba[15:0] - bb[15:0]});
            end else begin
                idle_x();
            end
            @(negedge clk);
        end

        // Asynchronous reset with two pairs in flight
        drive(32'h0200_0100, 32'h0100_0080, 3'd1);
        @(negedge clk);
        drive(32'h0300_0100, 32'h0100_0300, 3'd3);
        @(negedge clk);
        idle_x();
        check1("inflight_valid", fft_pe_valid, 1'b1);
        #2 rst = 1'b1;
        #1;
        check1("async_rst_valid", fft_pe_valid, 1'b0);
        check32("async_rst_fft_a", fft_a, 32'h0);
        check32("async_rst_fft_b", fft_b, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check1("post_rst_idle_valid", fft_pe_valid, 1'b0);
        end

        // First pair after release
        drive(32'h0200_0100, 32'h0100_0100, 3'd0);
        @(negedge clk);
        idle_x();
        check1("post_rst_latency", fft_pe_valid, 1'b0);
        @(negedge clk);
        check1("post_rst_valid", fft_pe_valid, 1'b1);
        check32("post_rst_fft_a", fft_a, 32'h0300_0200);
        check32("post_rst_fft_b", fft_b, 32'h0100_0000);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
